// File: rtl/sram_mem_controller.sv
// Sequences one 32-bit MEM-stage load/store as two timed 16-bit accesses to the
// board SRAM, holding the pipeline in stall until the word transfer completes.
module sram_mem_controller #(
  parameter int WAIT_CYCLES = 3,
  parameter int BASE_ADDR   = 1024,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic               stall,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n,
  output logic [1:0]         state_dbg
);

  // Handshake: a request is rd_en|wr_en held by the MEM stage; the controller
  // accepts it only in IDLE, runs it to completion regardless of later request
  // changes, and signals completion with a one-cycle ready pulse. stall is
  // request & ~ready, so a held request releases the pipeline exactly on ready.

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t             state, state_nx;
  logic [3:0]         cnt;
  logic [SRAM_AW-2:0] word_q;
  logic [31:0]        wdata_q;
  logic               rd_q;
  logic [31:0]        off;
  logic               last;
  logic               access;
  logic               unused_bits;

  assign off         = addr - 32'(BASE_ADDR);
  assign unused_bits = ^{off[31:SRAM_AW+1], off[1:0]};
  assign last        = (cnt == 4'(WAIT_CYCLES - 1));
  assign stall       = (rd_en | wr_en) & ~ready;
  assign state_dbg   = state;

  always_comb begin
    state_nx    = state;
    ready       = 1'b0;
    access      = 1'b0;
    sram_we_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    sram_dq_out = 16'h0000;
    case (state)
      IDLE: if (rd_en | wr_en) state_nx = LOW;
      LOW: begin
        access = 1'b1;
        if (last) state_nx = HIGH;
      end
      HIGH: begin
        access = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        ready    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Pads are only driven during write halves; reads keep DQ tristated.
    if (access && !rd_q) begin
      sram_we_n   = 1'b0;
      sram_dq_oe  = 1'b1;
      sram_dq_out = (state == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      word_q    <= '0;
      wdata_q   <= 32'h0;
      rd_q      <= 1'b0;
      rdata     <= 32'h0;
      sram_addr <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (rd_en | wr_en) begin
            // A simultaneous read and write resolves to the read.
            word_q    <= off[SRAM_AW:2];
            wdata_q   <= wdata;
            rd_q      <= rd_en;
            cnt       <= 4'd0;
            sram_addr <= {off[SRAM_AW:2], 1'b0};
          end
        end
        LOW: begin
          if (last) begin
            cnt       <= 4'd0;
            sram_addr <= {word_q, 1'b1};
            if (rd_q) rdata[15:0] <= sram_dq_in;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HIGH: begin
          if (last) begin
            cnt <= 4'd0;
            if (rd_q) rdata[31:16] <= sram_dq_in;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: cnt <= 4'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: a transaction-level timing model checked every
// cycle, directed load/store vectors with literal expectations, and a WAIT_CYCLES=1 instance.
module tb_sram_mem_controller;

  localparam int W  = 3;
  localparam int AW = 18;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          rd_en, wr_en;
  logic [31:0]   addr, wdata, rdata;
  logic          ready, stall, sram_dq_oe, sram_we_n;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out, sram_dq_in;
  logic [1:0]    state_dbg;

  logic          rd1;
  logic [31:0]   addr1, rdata1;
  logic          ready1, stall1, oe1, we_n1;
  logic [AW-1:0] sram_addr1;
  logic [15:0]   dq_out1, dq_in1;
  logic [1:0]    state_dbg1;

  sram_mem_controller #(.WAIT_CYCLES(W), .BASE_ADDR(1024), .SRAM_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ready(ready), .stall(stall),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .state_dbg(state_dbg)
  );

  sram_mem_controller #(.WAIT_CYCLES(1), .BASE_ADDR(1024), .SRAM_AW(AW)) dut1 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd1), .wr_en(1'b0), .addr(addr1),
    .wdata(32'h0), .rdata(rdata1), .ready(ready1), .stall(stall1),
    .sram_addr(sram_addr1), .sram_dq_out(dq_out1), .sram_dq_oe(oe1),
    .sram_dq_in(dq_in1), .sram_we_n(we_n1), .state_dbg(state_dbg1)
  );

  // ---------------- SRAM models ----------------
  bit [15:0]  sram_mem [0:255];
  logic       preload_en;
  logic [7:0] preload_addr;
  logic [15:0] preload_data;

  always @(posedge clk) begin
    if (preload_en) sram_mem[preload_addr] <= preload_data;
    else if (!sram_we_n) sram_mem[sram_addr[7:0]] <= sram_dq_out;
  end
  assign sram_dq_in = sram_mem[sram_addr[7:0]];
  assign dq_in1     = sram_addr1[15:0] ^ 16'h5A5A;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transaction model: a request seen while idle starts a transfer; phase p
  // counts cycles since acceptance. Phases 1..W address the low half, W+1..2W
  // the high half, and phase 2W+1 completes it.
  bit [15:0]     exp_mem [0:255];
  bit            m_busy;
  bit            m_rd;
  int            m_start;
  logic [AW-2:0] m_word;
  logic [31:0]   m_wdata, m_rdata, m_off;
  logic [AW-1:0] lo_a, hi_a;

  always @(negedge clk) begin
    int  p;
    bit  exp_ready, exp_wr;
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_rdata = 32'h0;
      check("rst_ready", ready, 1'b0);
      check("rst_we_n", sram_we_n, 1'b1);
      check("rst_oe", sram_dq_oe, 1'b0);
      check("rst_rdata", rdata, 32'h0);
    end else begin
      if (preload_en) exp_mem[preload_addr] = preload_data;
      if (!m_busy) check("idle_rdata", rdata, m_rdata);
      if (!m_busy && (rd_en || wr_en)) begin
        m_busy  = 1'b1;
        m_start = cyc;
        m_rd    = rd_en;
        m_off   = addr - 32'd1024;
        m_word  = m_off[AW:2];
        m_wdata = wdata;
      end
      p         = cyc - m_start;
      exp_ready = m_busy && (p == 2*W + 1);
      exp_wr    = m_busy && !m_rd && (p >= 1) && (p <= 2*W);
      lo_a      = {m_word, 1'b0};
      hi_a      = {m_word, 1'b1};
      check("ready", ready, exp_ready);
      check("stall", stall, (rd_en || wr_en) && !exp_ready);
      check("we_n", sram_we_n, !exp_wr);
      check("dq_oe", sram_dq_oe, exp_wr);
      if (m_busy && p >= 1 && p <= 2*W) begin
        check("sram_addr", sram_addr, (p > W) ? hi_a : lo_a);
        if (exp_wr) check("dq_out", sram_dq_out, (p > W) ? m_wdata[31:16] : m_wdata[15:0]);
      end
      if (exp_ready) begin
        if (m_rd) begin
          m_rdata = {exp_mem[hi_a[7:0]], exp_mem[lo_a[7:0]]};
          check("rdata", rdata, m_rdata);
        end else begin
          exp_mem[lo_a[7:0]] = m_wdata[15:0];
          exp_mem[hi_a[7:0]] = m_wdata[31:16];
          check("sram_lo", sram_mem[lo_a[7:0]], m_wdata[15:0]);
          check("sram_hi", sram_mem[hi_a[7:0]], m_wdata[31:16]);
        end
        m_busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    preload_en = 1'b1; preload_addr = a; preload_data = d;
    @(posedge clk); #1;
    preload_en = 1'b0;
  endtask

  // Issues a request at the current cycle; scrambles addr/wdata once accepted
  // and optionally drops the request at cycle drop_at.
  task automatic do_op(input string name, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, input int drop_at,
                       input int exp_stall, input logic chk_rd, input logic [31:0] exp_rd);
    int c, stall_cnt;
    bit got;
    rd_en = rd; wr_en = wr; addr = a; wdata = d;
    c = 0; stall_cnt = 0; got = 0;
    while (c < 40 && !got) begin
      @(negedge clk);
      if (stall) stall_cnt++;
      if (ready) got = 1;
      else begin
        @(posedge clk); #1;
        c++;
        if (c == 1) begin addr = ~a; wdata = ~d; end
        if (c == drop_at) begin rd_en = 1'b0; wr_en = 1'b0; end
      end
    end
    check({name, "_done"}, got, 1'b1);
    check({name, "_latency"}, c, 2*W + 1);
    check({name, "_stall_cycles"}, stall_cnt, exp_stall);
    if (chk_rd) check({name, "_rdata"}, rdata, exp_rd);
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n_ready;
    int exp_cyc [2];
    rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0; addr = 32'h0; wdata = 32'h0;
    rd1 = 1'b0; addr1 = 32'h0;
    preload_en = 1'b0; preload_addr = 8'h0; preload_data = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_sram_addr", sram_addr, 18'h0);
    check("reset_stall", stall, 1'b0);
    check("reset_state", state_dbg, 2'd0);
    @(negedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("wr_1024", 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 0, 7, 1'b0, 32'h0);
    check("mem0", sram_mem[0], 16'hBEEF);
    check("mem1", sram_mem[1], 16'hDEAD);
    do_op("rd_1024", 1'b1, 1'b0, 32'd1024, 32'h0, 0, 7, 1'b1, 32'hDEADBEEF);

    do_op("wr_1036", 1'b0, 1'b1, 32'd1036, 32'hCAFEF00D, 0, 7, 1'b0, 32'h0);
    check("mem6", sram_mem[6], 16'hF00D);
    check("mem7", sram_mem[7], 16'hCAFE);
    do_op("rd_1039", 1'b1, 1'b0, 32'd1039, 32'h0, 0, 7, 1'b1, 32'hCAFEF00D);

    preload(8'd2, 16'h2222);
    preload(8'd3, 16'h3333);
    do_op("rdwr_1028", 1'b1, 1'b1, 32'd1028, 32'h99999999, 0, 7, 1'b1, 32'h33332222);
    check("mem2_kept", sram_mem[2], 16'h2222);
    check("mem3_kept", sram_mem[3], 16'h3333);

    do_op("flush_wr", 1'b0, 1'b1, 32'd1024, 32'h12345678, 2, 2, 1'b0, 32'h0);
    check("flush_mem0", sram_mem[0], 16'h5678);
    check("flush_mem1", sram_mem[1], 16'h1234);

    // Reset while the read is in its high half.
    rd_en = 1'b1; addr = 32'd1024;
    repeat (5) begin @(posedge clk); #1; end
    check("pre_reset_rdata", rdata, 32'h33335678);
    #2; rst_n = 1'b0; rd_en = 1'b0;
    #1;
    check("async_we_n", sram_we_n, 1'b1);
    check("async_oe", sram_dq_oe, 1'b0);
    check("async_ready", ready, 1'b0);
    check("async_rdata", rdata, 32'h0);
    check("async_state", state_dbg, 2'd0);
    @(negedge clk); @(negedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("rd_after_rst", 1'b1, 1'b0, 32'd1024, 32'h0, 0, 7, 1'b1, 32'h12345678);

    // WAIT_CYCLES=1: held read request gives back-to-back transfers.
    exp_q.push_back(32'h5A5F5A5E);
    exp_q.push_back(32'h5A535A52);
    exp_cyc[0] = 3; exp_cyc[1] = 7;
    n_ready = 0;
    rd1 = 1'b1; addr1 = 32'd1032;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ready1) begin
        if (n_ready < 2) check("w1_ready_cycle", c, exp_cyc[n_ready]);
        if (exp_q.size() > 0) check("w1_rdata", rdata1, exp_q.pop_front());
        else check("w1_extra_ready", ready1, 1'b0);
        n_ready++;
        if (n_ready == 1) addr1 = 32'd1040;
        else rd1 = 1'b0;
      end
      if (c == 4) check("w1_gap_stall", stall1, 1'b1);
      @(posedge clk); #1;
    end
    check("w1_ready_count", n_ready, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
